// File: rtl/lisnoc_vc_link_scheduler_pkg.sv
// Shared types and constants for the vchannel link scheduler.
//  - Flit type encodings (payload/header/last/single), as used across lisnoc.
//  - Scheduler FSM state type.
//  - Helper that tells whether a flit type keeps a packet open.
package lisnoc_vc_link_scheduler_pkg;

    localparam logic [1:0] FLIT_TYPE_PAYLOAD = 2'b00;
    localparam logic [1:0] FLIT_TYPE_HEADER  = 2'b01;
    localparam logic [1:0] FLIT_TYPE_LAST    = 2'b10;
    localparam logic [1:0] FLIT_TYPE_SINGLE  = 2'b11;

    typedef enum logic [0:0] {
        StIdle,
        StHold
    } sched_state_e;

    // True for flits after which more flits of the same packet follow.
    function automatic logic flit_type_opens(input logic [1:0] flit_type);
        return (flit_type == FLIT_TYPE_HEADER) || (flit_type == FLIT_TYPE_PAYLOAD);
    endfunction

endpackage

// File: rtl/lisnoc_arb_rr.sv
// Combinational round-robin arbiter.
//  req_i      requests, one bit per requester
//  gnt_i      one-hot previous grant (search starts after this position)
//  nxt_gnt_o  one-hot grant of the first requester after gnt_i, zero if no request
module lisnoc_arb_rr #(
    parameter int unsigned N = 2
) (
    input  logic [N-1:0] req_i,
    input  logic [N-1:0] gnt_i,
    output logic [N-1:0] nxt_gnt_o
);

    int unsigned last_idx;
    int unsigned idx;
    logic        found;

    always_comb begin
        nxt_gnt_o = '0;
        last_idx  = N - 1;
        idx       = 0;
        found     = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (gnt_i[i]) begin
                last_idx = i;
            end
        end
        // Offset N wraps back to the previous grant itself, so it ranks last.
        for (int unsigned k = 1; k <= N; k++) begin
            idx = (last_idx + k) % N;
            if (!found && req_i[idx]) begin
                nxt_gnt_o[idx] = 1'b1;
                found          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lisnoc_vc_link_scheduler.sv
// Shares one physical output link between the vchannels of a router port.
// Picks one eligible vchannel (valid and downstream ready) per cycle, round-robin, and holds
// the grant for up to `burst` flits or until the packet ends. Transfer is combinational.
// Ports:
//  clk, rst   clock, synchronous active-high reset
//  flit_i     flit per VC FIFO, VC v at [fw*(v+1)-1:fw*v]
//  valid_i    per-VC FIFO non-empty
//  ready_o    one-hot pop strobe back to the VC FIFOs
//  flit_o     flit on the link
//  valid_o    one-hot VC tag/valid on the link
//  ready_i    per-VC downstream ready/credit
// Build option: LISNOC_VC_SCHED_PRIO_EN makes VC0 strict priority over the round-robin.
module lisnoc_vc_link_scheduler
    import lisnoc_vc_link_scheduler_pkg::*;
#(
    parameter int unsigned flit_data_width = 32,
    parameter int unsigned flit_type_width = 2,
    parameter int unsigned vchannels       = 3,
    parameter int unsigned burst           = 4
) (
    input  logic                                                   clk,
    input  logic                                                   rst,
    input  logic [(flit_data_width+flit_type_width)*vchannels-1:0] flit_i,
    input  logic [vchannels-1:0]                                   valid_i,
    output logic [vchannels-1:0]                                   ready_o,
    output logic [flit_data_width+flit_type_width-1:0]             flit_o,
    output logic [vchannels-1:0]                                   valid_o,
    input  logic [vchannels-1:0]                                   ready_i
);

    localparam int unsigned FW   = flit_data_width + flit_type_width;
    localparam int unsigned CntW = $clog2(burst + 1);
    localparam int unsigned IdxW = (vchannels > 1) ? $clog2(vchannels) : 1;
    localparam logic [CntW-1:0] BurstCnt = CntW'(burst);

    sched_state_e        state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d, cnt_inc;
    logic [IdxW-1:0]     last_q, last_d;
    logic [IdxW-1:0]     cur_q, cur_d;

    logic [vchannels-1:0] elig;
    logic [vchannels-1:0] last_oh;
    logic [vchannels-1:0] rr_gnt;
    logic [IdxW-1:0]      rr_idx;
    logic [IdxW-1:0]      sel_idx;
    logic                 xfer;
    logic                 new_grant;  // grant taken by the IDLE rules (RR or priority)
    logic                 upd_last;
    logic [FW-1:0]        sel_flit;
    logic [FW-1:0]        last_flit;
    logic [flit_type_width-1:0] sel_type;
    logic                 sel_open;

    assign elig = valid_i & ready_i;

    always_comb begin
        last_oh         = '0;
        last_oh[last_q] = 1'b1;
    end

    lisnoc_arb_rr #(
        .N (vchannels)
    ) u_arb (
        .req_i     (elig),
        .gnt_i     (last_oh),
        .nxt_gnt_o (rr_gnt)
    );

    always_comb begin
        rr_idx = '0;
        for (int unsigned v = 0; v < vchannels; v++) begin
            if (rr_gnt[v]) begin
                rr_idx = IdxW'(v);
            end
        end
    end

    // Grant selection for this cycle.
    always_comb begin
        xfer      = 1'b0;
        sel_idx   = last_q;
        new_grant = 1'b0;
        upd_last  = 1'b0;
        unique case (state_q)
            StIdle: begin
`ifdef LISNOC_VC_SCHED_PRIO_EN
                if (elig[0]) begin
                    xfer      = 1'b1;
                    sel_idx   = '0;
                    new_grant = 1'b1;
                end else
`endif
                if (|elig) begin
                    xfer      = 1'b1;
                    sel_idx   = rr_idx;
                    new_grant = 1'b1;
                    upd_last  = 1'b1;
                end
            end
            StHold: begin
`ifdef LISNOC_VC_SCHED_PRIO_EN
                if (cur_q != '0 && elig[0]) begin
                    xfer      = 1'b1;
                    sel_idx   = '0;
                    new_grant = 1'b1;
                end else
`endif
                if (elig[cur_q]) begin
                    xfer    = 1'b1;
                    sel_idx = cur_q;
                end
            end
            default: ;
        endcase
        // Nothing leaves the block while reset is asserted.
        if (rst) begin
            xfer = 1'b0;
        end
    end

    // Link mux: granted flit, or the flit of `last` when idle.
    always_comb begin
        sel_flit  = '0;
        last_flit = '0;
        for (int unsigned v = 0; v < vchannels; v++) begin
            if (IdxW'(v) == sel_idx) begin
                sel_flit = flit_i[v*FW +: FW];
            end
            if (IdxW'(v) == last_q) begin
                last_flit = flit_i[v*FW +: FW];
            end
        end
    end

    assign sel_type = sel_flit[FW-1 -: flit_type_width];
    assign sel_open = flit_type_opens(2'(sel_type));
    assign cnt_inc  = (cnt_q == BurstCnt) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        cur_d   = cur_q;
        if (xfer) begin
            if (new_grant) begin
                if (upd_last) begin
                    last_d = sel_idx;
                end
                if (burst > 1 && sel_open) begin
                    state_d = StHold;
                    cur_d   = sel_idx;
                    cnt_d   = CntW'(1);
                end else begin
                    state_d = StIdle;
                end
            end else begin
                cnt_d = cnt_inc;
                if (!sel_open || cnt_inc == BurstCnt) begin
                    state_d = StIdle;
                end
            end
        end else if (state_q == StHold) begin
            // Stalled grant is dropped; `last` stays so other VCs rank ahead.
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            last_q  <= IdxW'(vchannels - 1);
            cur_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            cur_q   <= cur_d;
        end
    end

    always_comb begin
        valid_o = '0;
        for (int unsigned v = 0; v < vchannels; v++) begin
            valid_o[v] = xfer && (sel_idx == IdxW'(v));
        end
    end

    assign ready_o = valid_o;
    assign flit_o  = xfer ? sel_flit : last_flit;

endmodule

// File: tb/tb_lisnoc_vc_link_scheduler.sv
// Directed bench for lisnoc_vc_link_scheduler (3 VCs, burst 4, 34-bit flits).
// Expected link outputs are queued per step and popped at the following falling edge.
module tb_lisnoc_vc_link_scheduler;

    localparam logic [1:0] PAY = 2'b00;
    localparam logic [1:0] HDR = 2'b01;
    localparam logic [1:0] LST = 2'b10;
    localparam logic [1:0] SGL = 2'b11;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [33:0]  fl [3];
    logic [101:0] flit_i;
    logic [2:0]   valid_i, ready_i, ready_o, valid_o;
    logic [33:0]  flit_o;

    typedef struct packed {
        logic [2:0]  vo;
        logic [33:0] fl;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    assign flit_i = {fl[2], fl[1], fl[0]};

    lisnoc_vc_link_scheduler #(
        .flit_data_width (32),
        .flit_type_width (2),
        .vchannels       (3),
        .burst           (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .flit_i  (flit_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .flit_o  (flit_o),
        .valid_o (valid_o),
        .ready_i (ready_i)
    );

    task automatic set_vc(input int v, input logic vld, input logic [1:0] t,
                          input logic [31:0] d);
        valid_i[v] = vld;
        fl[v]      = {t, d};
    endtask

    // One clock step: queue expectation, compare at the falling edge, advance.
    task automatic cyc(input string tag, input logic [2:0] vo, input int fvc);
        exp_t  e;
        string t;
        e.vo = vo;
        e.fl = fl[fvc];
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        assert (valid_o === e.vo) else begin
            errors++;
            $error("FAIL %s valid_o: got %b expected %b", t, valid_o, e.vo);
        end
        checks++;
        assert (ready_o === e.vo) else begin
            errors++;
            $error("FAIL %s ready_o: got %b expected %b", t, ready_o, e.vo);
        end
        checks++;
        assert (flit_o === e.fl) else begin
            errors++;
            $error("FAIL %s flit_o: got %h expected %h", t, flit_o, e.fl);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        valid_i = '0;
        ready_i = 3'b111;
        for (int v = 0; v < 3; v++) fl[v] = '0;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Reset: nothing granted, link shows flit of last = VC2.
        set_vc(0, 1'b1, SGL, 32'h1000_0000);
        set_vc(1, 1'b1, SGL, 32'h1100_0000);
        set_vc(2, 1'b1, SGL, 32'h1200_0000);
        cyc("reset_idle", 3'b000, 2);
        rst = 1'b0;

        // 1: all SINGLE, plain rotation starting at VC0.
        cyc("t1_rr0", 3'b001, 0);
        cyc("t1_rr1", 3'b010, 1);
        cyc("t1_rr2", 3'b100, 2);
        cyc("t1_rr3", 3'b001, 0);
        valid_i = '0;
        cyc("t1_empty", 3'b000, 0);

        // 2: VC1 alone, 6-flit packet, burst cut after 4 then immediate re-pick.
        set_vc(1, 1'b1, HDR, 32'h2000_0000);
        cyc("t2_hdr", 3'b010, 1);
        for (int i = 1; i <= 4; i++) begin
            set_vc(1, 1'b1, PAY, 32'h2000_0000 + i);
            cyc("t2_pay", 3'b010, 1);
        end
        set_vc(1, 1'b1, LST, 32'h2000_0005);
        cyc("t2_last", 3'b010, 1);
        // Back in IDLE: round-robin after VC1 picks VC2, not VC1.
        set_vc(0, 1'b1, SGL, 32'h2000_0100);
        set_vc(1, 1'b1, SGL, 32'h2000_0101);
        set_vc(2, 1'b1, SGL, 32'h2000_0102);
        cyc("t2_idle_pick", 3'b100, 2);

        // 3: VC0 and VC2 3-flit packets, no interleave.
        set_vc(0, 1'b1, HDR, 32'h3000_0000);
        set_vc(1, 1'b0, PAY, 32'h3100_0000);
        set_vc(2, 1'b1, HDR, 32'h3200_0000);
        cyc("t3_v0_h", 3'b001, 0);
        set_vc(0, 1'b1, PAY, 32'h3000_0001);
        cyc("t3_v0_p", 3'b001, 0);
        set_vc(0, 1'b1, LST, 32'h3000_0002);
        cyc("t3_v0_l", 3'b001, 0);
        set_vc(0, 1'b1, HDR, 32'h3000_0010);
        cyc("t3_v2_h", 3'b100, 2);
        set_vc(2, 1'b1, PAY, 32'h3200_0001);
        cyc("t3_v2_p", 3'b100, 2);
        set_vc(2, 1'b1, LST, 32'h3200_0002);
        cyc("t3_v2_l", 3'b100, 2);
        set_vc(2, 1'b0, LST, 32'h3200_0002);

        // 3b: burst expiry with a competitor rotates mid-packet.
        cyc("t3b_h", 3'b001, 0);
        set_vc(2, 1'b1, SGL, 32'h3b20_0000);
        for (int i = 1; i <= 3; i++) begin
            set_vc(0, 1'b1, PAY, 32'h3b00_0000 + i);
            cyc("t3b_pay", 3'b001, 0);
        end
        set_vc(0, 1'b1, PAY, 32'h3b00_0004);
        cyc("t3b_rotate", 3'b100, 2);
        set_vc(2, 1'b0, SGL, 32'h3b20_0000);
        cyc("t3b_resume", 3'b001, 0);
        set_vc(0, 1'b1, LST, 32'h3b00_0005);
        cyc("t3b_last", 3'b001, 0);
        set_vc(0, 1'b0, LST, 32'h3b00_0005);

        // 4: HOLD on VC1 stalls one cycle, VC2 slips in, VC1 resumes.
        set_vc(1, 1'b1, HDR, 32'h4100_0000);
        set_vc(2, 1'b1, SGL, 32'h4200_0000);
        cyc("t4_h", 3'b010, 1);
        set_vc(1, 1'b1, PAY, 32'h4100_0001);
        ready_i = 3'b101;
        cyc("t4_stall", 3'b000, 1);
        ready_i = 3'b111;
        cyc("t4_v2", 3'b100, 2);
        set_vc(2, 1'b0, SGL, 32'h4200_0000);
        cyc("t4_resume", 3'b010, 1);
        set_vc(1, 1'b1, LST, 32'h4100_0002);
        cyc("t4_last", 3'b010, 1);
        set_vc(1, 1'b0, LST, 32'h4100_0002);

        // 5: VC0 SINGLE arriving while VC2 holds.
        set_vc(2, 1'b1, HDR, 32'h5200_0000);
        cyc("t5_h", 3'b100, 2);
        set_vc(2, 1'b1, PAY, 32'h5200_0001);
        set_vc(0, 1'b1, SGL, 32'h5000_0000);
`ifdef LISNOC_VC_SCHED_PRIO_EN
        cyc("t5_prio", 3'b001, 0);
        set_vc(0, 1'b0, SGL, 32'h5000_0000);
        cyc("t5_resume", 3'b100, 2);
        set_vc(2, 1'b1, LST, 32'h5200_0002);
        cyc("t5_last", 3'b100, 2);
        set_vc(2, 1'b0, LST, 32'h5200_0002);
`else
        cyc("t5_rr_hold", 3'b100, 2);
        set_vc(2, 1'b1, LST, 32'h5200_0002);
        cyc("t5_rr_last", 3'b100, 2);
        set_vc(2, 1'b0, LST, 32'h5200_0002);
        cyc("t5_rr_v0", 3'b001, 0);
        set_vc(0, 1'b0, SGL, 32'h5000_0000);
`endif

        // 6: reset during HOLD drops the grant and restores VC0 first pick.
        set_vc(1, 1'b1, HDR, 32'h6100_0000);
        cyc("t6_h", 3'b010, 1);
        set_vc(1, 1'b1, PAY, 32'h6100_0001);
        rst = 1'b1;
        cyc("t6_rst", 3'b000, 1);
        rst = 1'b0;
        set_vc(0, 1'b1, SGL, 32'h6000_0010);
        set_vc(1, 1'b1, SGL, 32'h6100_0010);
        set_vc(2, 1'b1, SGL, 32'h6200_0010);
        cyc("t6_first", 3'b001, 0);
        cyc("t6_second", 3'b010, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
